// File: rtl/mem_pkg.sv
// Shared types and decode helpers for the load/store initiator.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Access size in bytes (1/2/4) from the low funct3 bits.
    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Unsigned variants exist only for loads; 011/110/111 never exist.
    function automatic logic f3_illegal(input logic [2:0] funct3, input logic we);
        return (funct3 == 3'b011) || (funct3[2] && (funct3[1] || we));
    endfunction

    function automatic logic crosses(input logic [1:0] off, input logic [2:0] funct3);
        return ({2'b00, off} + {1'b0, size_of(funct3)}) > 4'd4;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    input  logic [31:0] wdata,
    output logic [7:0]  mask8,
    output logic [63:0] data64,
    output logic [31:0] load_val
);

    logic [3:0]  size_mask;
    logic [63:0] raw64;

    always_comb begin
        case (funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        mask8  = {4'b0000, size_mask} << off;
        data64 = {32'h0, wdata} << {off, 3'b000};
        raw64  = {hi_word, lo_word} >> {off, 3'b000};
        case (funct3)
            F3_B:    load_val = {{24{raw64[7]}}, raw64[7:0]};
            F3_H:    load_val = {{16{raw64[15]}}, raw64[15:0]};
            F3_BU:   load_val = {24'h0, raw64[7:0]};
            F3_HU:   load_val = {16'h0, raw64[15:0]};
            default: load_val = raw64[31:0];
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, boundary-crossing accesses
// split into two aligned word accesses.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_wr,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata0,
    output logic [7:0]  mem_wdata1,
    output logic [7:0]  mem_wdata2,
    output logic [7:0]  mem_wdata3,
    input  logic [31:0] mem_rdata
);

    state_t      state, state_nx;
    mem_req_t    req_q;
    logic        err_q;
    logic [31:0] lo_word, hi_word;
    logic        in_err;
    logic [31:0] word_addr;
    logic [7:0]  mask8;
    logic [63:0] data64;
    logic [31:0] load_val;
    logic [31:0] lanes;

    assign in_err    = f3_illegal(req_funct3, req_we) ||
                       (!ALLOW_MISALIGNED && crosses(req_addr[1:0], req_funct3));
    assign word_addr = {req_q.addr[31:2], 2'b00};

    mem_lane_align u_align (
        .funct3   (req_q.funct3),
        .off      (req_q.addr[1:0]),
        .lo_word  (lo_word),
        .hi_word  (hi_word),
        .wdata    (req_q.wdata),
        .mask8    (mask8),
        .data64   (data64),
        .load_val (load_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            req_q   <= '0;
            err_q   <= 1'b0;
            lo_word <= '0;
            hi_word <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    req_q   <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                    err_q   <= in_err;
                    lo_word <= '0;
                    hi_word <= '0;  // stays 0 for non-split loads
                end
                ACC0:    lo_word <= mem_rdata;
                ACC1:    hi_word <= mem_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_en     = 1'b0;
        mem_wr     = 4'b0000;
        mem_addr   = '0;
        lanes      = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = in_err ? RESP : ACC0;
            end
            ACC0: begin
                mem_en   = 1'b1;
                mem_addr = word_addr;
                mem_wr   = req_q.we ? mask8[3:0] : 4'b0000;
                lanes    = data64[31:0];
                state_nx = crosses(req_q.addr[1:0], req_q.funct3) ? ACC1 : RESP;
            end
            ACC1: begin
                mem_en   = 1'b1;
                mem_addr = word_addr + 32'd4;
                mem_wr   = req_q.we ? mask8[7:4] : 4'b0000;
                lanes    = data64[63:32];
                state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !req_q.we) resp_rdata = load_val;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_wdata0 = lanes[7:0];
    assign mem_wdata1 = lanes[15:8];
    assign mem_wdata2 = lanes[23:16];
    assign mem_wdata3 = lanes[31:24];

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed vector bench for mem_access_unit with a behavioural byte-lane RAM.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_a, req_valid_b;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready_a, req_ready_b, resp_valid_a, resp_valid_b, resp_err_a, resp_err_b;
    logic [31:0] resp_rdata_a, resp_rdata_b;
    logic        mem_en_a, mem_en_b;
    logic [3:0]  mem_wr_a, mem_wr_b;
    logic [31:0] mem_addr_a, mem_addr_b, mem_rdata_a, mem_rdata_b;
    logic [7:0]  w0a, w1a, w2a, w3a, w0b, w1b, w2b, w3b;
    logic        mem_clr;
    logic [31:0] mem [64];
    logic        sel;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ALLOW_MISALIGNED(1'b1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_a), .resp_err(resp_err_a), .resp_rdata(resp_rdata_a),
        .mem_en(mem_en_a), .mem_wr(mem_wr_a), .mem_addr(mem_addr_a),
        .mem_wdata0(w0a), .mem_wdata1(w1a), .mem_wdata2(w2a), .mem_wdata3(w3a),
        .mem_rdata(mem_rdata_a));

    mem_access_unit #(.ALLOW_MISALIGNED(1'b0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_err(resp_err_b), .resp_rdata(resp_rdata_b),
        .mem_en(mem_en_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b),
        .mem_wdata0(w0b), .mem_wdata1(w1b), .mem_wdata2(w2b), .mem_wdata3(w3b),
        .mem_rdata(mem_rdata_b));

    // Combinational-read RAM, 64 words, aliased on address bits [7:2].
    assign mem_rdata_a = mem[mem_addr_a[7:2]];
    assign mem_rdata_b = mem[mem_addr_b[7:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mem_en_a && mem_wr_a[i]) mem[mem_addr_a[7:2]][8*i +: 8] <= {w3a, w2a, w1a, w0a}[8*i +: 8];
                if (mem_en_b && mem_wr_b[i]) mem[mem_addr_b[7:2]][8*i +: 8] <= {w3b, w2b, w1b, w0b}[8*i +: 8];
            end
        end
    end

    logic        s_ready, s_rv, s_err, s_en;
    logic [3:0]  s_wr;
    logic [31:0] s_rdata, s_addr, s_lanes;
    assign s_ready = sel ? req_ready_b  : req_ready_a;
    assign s_rv    = sel ? resp_valid_b : resp_valid_a;
    assign s_err   = sel ? resp_err_b   : resp_err_a;
    assign s_rdata = sel ? resp_rdata_b : resp_rdata_a;
    assign s_en    = sel ? mem_en_b     : mem_en_a;
    assign s_wr    = sel ? mem_wr_b     : mem_wr_a;
    assign s_addr  = sel ? mem_addr_b   : mem_addr_a;
    assign s_lanes = sel ? {w3b, w2b, w1b, w0b} : {w3a, w2a, w1a, w0a};

    typedef struct {
        bit          dut;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        int          lat;
        bit          err;
        logic [31:0] rdata;
        int          nacc;
        logic [31:0] a0;
        logic [3:0]  wr0;
        logic [31:0] ln0;
        logic [31:0] a1;
        logic [3:0]  wr1;
        logic [31:0] ln1;
    } vec_t;

    function automatic vec_t mk(bit dut, bit we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                int lat, bit err, logic [31:0] rdata, int nacc,
                                logic [31:0] a0, logic [3:0] wr0, logic [31:0] ln0,
                                logic [31:0] a1, logic [3:0] wr1, logic [31:0] ln1);
        vec_t v;
        v.dut = dut; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.err = err; v.rdata = rdata; v.nacc = nacc;
        v.a0 = a0; v.wr0 = wr0; v.ln0 = ln0; v.a1 = a1; v.wr1 = wr1; v.ln1 = ln1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat = 0, nresp = 0, nacc = 0;
        @(negedge clk);
        sel         = v.dut;
        req_we      = v.we;
        req_funct3  = v.f3;
        req_addr    = v.addr;
        req_wdata   = v.wdata;
        req_valid_a = !v.dut;
        req_valid_b = v.dut;
        #1;
        chk({tag, "_ready0"}, 32'(s_ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid_a = 1'b0;
            req_valid_b = 1'b0;
            chk($sformatf("%s_ready%0d", tag, k), 32'(s_ready), 32'(k > v.lat));
            if (s_rv) begin
                nresp++;
                if (lat == 0) begin
                    lat = k;
                    chk({tag, "_err"}, 32'(s_err), 32'(v.err));
                    chk({tag, "_rdata"}, s_rdata, v.rdata);
                end
            end
            if (s_en) begin
                nacc++;
                chk($sformatf("%s_addr%0d", tag, nacc), s_addr, (nacc == 1) ? v.a0 : v.a1);
                chk($sformatf("%s_wr%0d", tag, nacc), 32'(s_wr), 32'((nacc == 1) ? v.wr0 : v.wr1));
                if (v.we) chk($sformatf("%s_lanes%0d", tag, nacc), s_lanes, (nacc == 1) ? v.ln0 : v.ln1);
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(v.lat));
        chk({tag, "_nresp"}, 32'(nresp), 32'd1);
        chk({tag, "_naccess"}, 32'(nacc), 32'(v.nacc));
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = mk(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0);
        vecs[1]  = mk(0, 0, 3'b000, 32'h13, 32'h0, 2, 0, 32'hFFFFFFDE, 1, 32'h10, 4'h0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 3'b100, 32'h13, 32'h0, 2, 0, 32'h000000DE, 1, 32'h10, 4'h0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 3'b010, 32'h22, 32'h11223344, 3, 0, 32'h0, 2, 32'h20, 4'hC, 32'h33440000, 32'h24, 4'h3, 32'h00001122);
        vecs[4]  = mk(0, 0, 3'b010, 32'h22, 32'h0, 3, 0, 32'h11223344, 2, 32'h20, 4'h0, 0, 32'h24, 4'h0, 0);
        vecs[5]  = mk(0, 1, 3'b000, 32'h07, 32'h80, 2, 0, 32'h0, 1, 32'h04, 4'h8, 32'h80000000, 0, 0, 0);
        vecs[6]  = mk(0, 1, 3'b000, 32'h08, 32'h90, 2, 0, 32'h0, 1, 32'h08, 4'h1, 32'h00000090, 0, 0, 0);
        vecs[7]  = mk(0, 0, 3'b001, 32'h07, 32'h0, 3, 0, 32'hFFFF9080, 2, 32'h04, 4'h0, 0, 32'h08, 4'h0, 0);
        vecs[8]  = mk(0, 0, 3'b101, 32'h12, 32'h0, 2, 0, 32'h0000DEAD, 1, 32'h10, 4'h0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 3'b001, 32'h10, 32'h0, 2, 0, 32'hFFFFBEEF, 1, 32'h10, 4'h0, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 3'b010, 32'h10, 32'h0, 2, 0, 32'hDEADBEEF, 1, 32'h10, 4'h0, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 3'b011, 32'h10, 32'h0, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 1, 3'b100, 32'h10, 32'h55, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 3'b110, 32'h10, 32'h0, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 1, 3'b001, 32'h13, 32'hA5B6, 3, 0, 32'h0, 2, 32'h10, 4'h8, 32'hB6000000, 32'h14, 4'h1, 32'h000000A5);
        vecs[15] = mk(0, 0, 3'b000, 32'h13, 32'h0, 2, 0, 32'hFFFFFFB6, 1, 32'h10, 4'h0, 0, 0, 0, 0);
        vecs[16] = mk(1, 0, 3'b001, 32'h07, 32'h0, 1, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
        vecs[17] = mk(1, 0, 3'b010, 32'h10, 32'h0, 2, 0, 32'hB6ADBEEF, 1, 32'h10, 4'h0, 0, 0, 0, 0);
        vecs[18] = mk(1, 0, 3'b100, 32'h11, 32'h0, 2, 0, 32'h000000BE, 1, 32'h10, 4'h0, 0, 0, 0, 0);

        sel = 1'b0; rst = 1'b1; mem_clr = 1'b1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d[0];
            #1;
            chk($sformatf("rst%0d_ready", d), 32'(s_ready), 32'd1);
            chk($sformatf("rst%0d_rv", d), {30'h0, s_rv, s_err}, 32'h0);
            chk($sformatf("rst%0d_rdata", d), s_rdata, 32'h0);
            chk($sformatf("rst%0d_en_wr", d), {27'h0, s_en, s_wr}, 32'h0);
            chk($sformatf("rst%0d_addr", d), s_addr, 32'h0);
            chk($sformatf("rst%0d_lanes", d), s_lanes, 32'h0);
        end
        rst = 1'b0; mem_clr = 1'b0;

        for (int i = 0; i < 19; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Reset during the second half of a split store wrapping past 0xFFFFFFFC.
        @(negedge clk);
        sel = 1'b0;
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'hFFFFFFFE; req_wdata = 32'h55667788;
        req_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_a = 1'b0;
        chk("abort_acc0_en", 32'(s_en), 32'd1);
        chk("abort_acc0_addr", s_addr, 32'hFFFFFFFC);
        chk("abort_acc0_wr", 32'(s_wr), 32'hC);
        chk("abort_acc0_lanes", s_lanes, 32'h77880000);
        @(negedge clk);
        chk("abort_acc1_en", 32'(s_en), 32'd1);
        chk("abort_acc1_addr", s_addr, 32'h00000000);
        chk("abort_acc1_wr", 32'(s_wr), 32'h3);
        chk("abort_acc1_lanes", s_lanes, 32'h00005566);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_en", 32'(s_en), 32'd0);
        chk("abort_wr", 32'(s_wr), 32'd0);
        chk("abort_ready", 32'(s_ready), 32'd1);
        chk("abort_rv", 32'(s_rv), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort_norv%0d", k), 32'(s_rv), 32'd0);
        end
        run_vec("after_abort", mk(0, 0, 3'b010, 32'h0, 32'h0, 2, 0, 32'h00005566, 1, 32'h0, 4'h0, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
